// File: rtl/sha3_scan_pkg.sv
// rtl/sha3_scan_pkg.sv - shared job layout, sizes and FSM states for the scan job loader
package sha3_scan_pkg;

    localparam int TEMPLATE_WORDS = 24;
    localparam int JOB_WORDS      = 26;
    localparam int ACK_TIMEOUT    = 16;

    typedef struct packed {
        logic [TEMPLATE_WORDS-1:0][31:0] tmpl;
        logic [63:0]                     thresh;
    } scan_job_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_RUN
    } scan_state_t;

endpackage

// File: rtl/i_sha3_scan_request_bus.sv
// rtl/i_sha3_scan_request_bus.sv - scan request bus between job loader and scanner
interface i_sha3_scan_request_bus;

    logic        start;
    logic [63:0] threshold;
    logic [31:0] blockTemplate [24];

    modport producer (output start, output threshold, output blockTemplate);
    modport consumer (input start, input threshold, input blockTemplate);

endinterface

// File: rtl/scan_job_fill_bank.sv
// rtl/scan_job_fill_bank.sv - word counter, framing check and fill storage for the next job
module scan_job_fill_bank
    import sha3_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    input  logic        abort,
    input  logic        clear,
    output logic        full,
    output scan_job_t   job,
    output logic        framing_error
);

    localparam logic [4:0] TMPL_CNT = 5'(TEMPLATE_WORDS);
    localparam logic [4:0] LAST_IDX = 5'(JOB_WORDS - 1);

    logic [4:0] cnt;
    logic       accept;

    assign word_ready = !full && !abort;
    assign accept     = word_valid && word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            full          <= 1'b0;
            job           <= '0;
            framing_error <= 1'b0;
        end else if (abort || clear) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (accept) begin
            if (cnt < TMPL_CNT)
                job.tmpl[cnt] <= word_data;
            else if (cnt == TMPL_CNT)
                job.thresh[31:0] <= word_data;
            else
                job.thresh[63:32] <= word_data;

            // Any framing violation simply rewinds the counter; stale storage is overwritten by the next job.
            if (cnt == LAST_IDX) begin
                cnt <= '0;
                if (word_last)
                    full <= 1'b1;
                else
                    framing_error <= 1'b1;
            end else if (word_last) begin
                cnt           <= '0;
                framing_error <= 1'b1;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: rtl/scan_job_loader.sv
// rtl/scan_job_loader.sv - double-buffered scan job sequencer; SCAN_JOB_LOADER_ACK_TIMEOUT_EN adds the start-ack timeout
module scan_job_loader
    import sha3_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    input  logic        abort,
    input  logic        scanner_busy,
    output logic        job_pending,
    output logic        framing_error,
`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
    output logic        ack_timeout,
`endif
    i_sha3_scan_request_bus.producer as
);

    scan_state_t state;
    scan_job_t   fill_job;
    scan_job_t   active;
    logic        start_q;
    logic        clear;

    assign clear = (state == ST_ISSUE);

    scan_job_fill_bank u_fill (
        .clk           (clk),
        .rst_n         (rst_n),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_last     (word_last),
        .word_ready    (word_ready),
        .abort         (abort),
        .clear         (clear),
        .full          (job_pending),
        .job           (fill_job),
        .framing_error (framing_error)
    );

`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
    logic [7:0] ack_cnt;
`endif

    // The active bank is only written in ISSUE, so the bus is stable for the whole scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            active  <= '0;
`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
            ack_cnt     <= '0;
            ack_timeout <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_pending && !scanner_busy && !abort)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    active  <= fill_job;
                    start_q <= 1'b1;
                    state   <= ST_WAIT_ACK;
`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
                    ack_cnt <= '0;
`endif
                end
                ST_WAIT_ACK: begin
                    if (scanner_busy)
                        state <= ST_RUN;
`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
                    else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        ack_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else
                        ack_cnt <= ack_cnt + 8'd1;
`endif
                end
                ST_RUN: begin
                    if (!scanner_busy)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign as.start     = start_q;
    assign as.threshold = active.thresh;

    for (genvar i = 0; i < TEMPLATE_WORDS; i++) begin : g_tmpl
        assign as.blockTemplate[i] = active.tmpl[i];
    end

endmodule

// File: tb/tb_scan_job_loader.sv
// tb/tb_scan_job_loader.sv - directed self-checking bench for scan_job_loader
module tb_scan_job_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        abort;
    logic        scanner_busy;
    wire         word_ready;
    wire         job_pending;
    wire         framing_error;
`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
    wire         ack_timeout;
`endif

    i_sha3_scan_request_bus bus ();

    scan_job_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_last     (word_last),
        .word_ready    (word_ready),
        .abort         (abort),
        .scanner_busy  (scanner_busy),
        .job_pending   (job_pending),
        .framing_error (framing_error),
`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
        .ack_timeout   (ack_timeout),
`endif
        .as            (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int starts = 0;

    always @(posedge clk) begin
        #1;
        if (bus.start === 1'b1)
            starts++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic send_job(input logic [31:0] base, input logic [63:0] th);
        for (int i = 0; i < 24; i++)
            send_word(base + 32'(i), 1'b0);
        send_word(th[31:0], 1'b0);
        send_word(th[63:32], 1'b1);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (bus.start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(bus.start), 64'd1);
    endtask

    task automatic busy_pulse();
        cyc(1);
        scanner_busy = 1'b1;
        cyc(2);
        scanner_busy = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst_n        = 1'b0;
        word_valid   = 1'b0;
        word_data    = '0;
        word_last    = 1'b0;
        abort        = 1'b0;
        scanner_busy = 1'b0;
        cyc(2);
        chk("rst_pending", 64'(job_pending), 64'd0);
        chk("rst_start", 64'(bus.start), 64'd0);
        rst_n = 1'b1;
        cyc(1);

        // reset in the middle of a fill
        for (int i = 0; i < 10; i++)
            send_word(32'h900 + 32'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pending", 64'(job_pending), 64'd0);
        chk("midrst_ferr", 64'(framing_error), 64'd0);
        chk("midrst_thresh", bus.threshold, 64'd0);
        chk("midrst_bt0", 64'(bus.blockTemplate[0]), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // first job, scanner idle: minimum latency
        send_job(32'h100, 64'h8000_0000_0000_0001);
        chk("j1_pending_n1", 64'(job_pending), 64'd1);
        chk("j1_start_n1", 64'(bus.start), 64'd0);
        cyc(1);
        chk("j1_start_n2", 64'(bus.start), 64'd0);
        cyc(1);
        chk("j1_start", 64'(bus.start), 64'd1);
        chk("j1_pending_clr", 64'(job_pending), 64'd0);
        chk("j1_bt5", 64'(bus.blockTemplate[5]), 64'h105);
        chk("j1_bt23", 64'(bus.blockTemplate[23]), 64'h117);
        chk("j1_thresh", bus.threshold, 64'h8000_0000_0000_0001);
        cyc(1);
        chk("j1_start_pulse", 64'(bus.start), 64'd0);
        chk("j1_starts", 64'(starts), 64'd1);
        scanner_busy = 1'b1;
        cyc(2);

        // second job while the scanner is busy
        send_job(32'h200, 64'h1234_5678_9abc_def0);
        chk("j2_pending", 64'(job_pending), 64'd1);
        chk("j2_ready_low", 64'(word_ready), 64'd0);
        cyc(5);
        chk("j2_no_start", 64'(starts), 64'd1);
        chk("j2_bus_hold_th", bus.threshold, 64'h8000_0000_0000_0001);
        chk("j2_bus_hold_bt", 64'(bus.blockTemplate[5]), 64'h105);
        scanner_busy = 1'b0;
        wait_start("j2_start", 10);
        chk("j2_bt5", 64'(bus.blockTemplate[5]), 64'h205);
        chk("j2_thresh", bus.threshold, 64'h1234_5678_9abc_def0);
        chk("j2_starts", 64'(starts), 64'd2);
        busy_pulse();

        // word_last on index 12
        chk("fe_clear", 64'(framing_error), 64'd0);
        for (int i = 0; i <= 12; i++)
            send_word(32'h300 + 32'(i), i == 12);
        chk("fe_set", 64'(framing_error), 64'd1);
        chk("fe_pending", 64'(job_pending), 64'd0);
        cyc(5);
        chk("fe_no_start", 64'(starts), 64'd2);
        send_job(32'h400, 64'h0000_0004_0000_0003);
        wait_start("j3_start", 10);
        chk("j3_bt0", 64'(bus.blockTemplate[0]), 64'h400);
        chk("j3_bt12", 64'(bus.blockTemplate[12]), 64'h40c);
        chk("j3_thresh", bus.threshold, 64'h0000_0004_0000_0003);
        chk("fe_sticky", 64'(framing_error), 64'd1);
        busy_pulse();

        // abort together with word 25
        for (int i = 0; i < 25; i++)
            send_word(32'h500 + 32'(i), 1'b0);
        abort      = 1'b1;
        word_valid = 1'b1;
        word_data  = 32'h5555_5555;
        word_last  = 1'b1;
        #1;
        chk("ab_ready_low", 64'(word_ready), 64'd0);
        @(negedge clk);
        abort      = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        chk("ab_pending", 64'(job_pending), 64'd0);
        cyc(5);
        chk("ab_no_start", 64'(starts), 64'd3);
        chk("ab_pending_late", 64'(job_pending), 64'd0);
        send_job(32'h600, 64'h0000_0006_0000_0005);
        wait_start("j4_start", 10);
        chk("j4_bt0", 64'(bus.blockTemplate[0]), 64'h600);
        chk("j4_starts", 64'(starts), 64'd4);
        busy_pulse();

`ifdef SCAN_JOB_LOADER_ACK_TIMEOUT_EN
        // scanner never acknowledges
        send_job(32'h700, 64'h0000_0008_0000_0007);
        wait_start("to_start", 10);
        chk("to_clear", 64'(ack_timeout), 64'd0);
        cyc(15);
        chk("to_not_yet", 64'(ack_timeout), 64'd0);
        cyc(1);
        chk("to_set", 64'(ack_timeout), 64'd1);
        send_job(32'h800, 64'h0000_000a_0000_0009);
        wait_start("to_next_start", 10);
        chk("to_next_bt0", 64'(bus.blockTemplate[0]), 64'h800);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
